i2c_master_tx: RTL and testbench

- Single-byte I2C write master; the stage directly upstream of i2c_slave.
- Takes a 7-bit slave address and one data byte from the host side, then generates START, address+W, data, STOP on scl/sda.
- Checks both ACK slots and reports completion and ACK errors.
- Output drives the i2c_slave scl input and the shared open-drain sda line, which feeds the LED path downstream.

---
 rtl/i2c_master_tx.sv | 165 ++++++++++++++++
 tb/tb_i2c_master_tx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_tx.sv
// i2c_master_tx: single-byte I2C write master.
// Sends START, addr+W, data, STOP and checks both ACK slots.
module i2c_master_tx #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  output logic       sda_oe,
  input  logic       sda_i
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DMAX = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, ADDR, ACK1, DATA, ACK2, STOP
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    q, q_nx;
  logic [DW-1:0] div, div_nx;
  logic [2:0]    bitcnt, bitcnt_nx;
  logic [7:0]    shift, shift_nx;
  logic [7:0]    dbyte, dbyte_nx;
  logic          busy_nx, done_nx, aerr_nx;
  logic          scl_nx, oe_nx;
  logic          tick;

  assign tick = (state != IDLE) && (div == DMAX);

  always_comb begin
    state_nx  = state;
    q_nx      = q;
    div_nx    = div + DW'(1);
    bitcnt_nx = bitcnt;
    shift_nx  = shift;
    dbyte_nx  = dbyte;
    busy_nx   = busy;
    done_nx   = 1'b0;
    aerr_nx   = ack_err;
    if (state == IDLE || tick)
      div_nx = '0;
    if (tick)
      q_nx = q + 2'd1;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx  = START;
          q_nx      = 2'd0;
          shift_nx  = {addr, 1'b0};
          dbyte_nx  = wdata;
          bitcnt_nx = 3'd7;
          busy_nx   = 1'b1;
          aerr_nx   = 1'b0;
        end
      end
      START: begin
        if (tick && q == 2'd3) begin
          state_nx  = ADDR;
          bitcnt_nx = 3'd7;
        end
      end
      ADDR, DATA: begin
        if (tick && q == 2'd3) begin
          if (bitcnt == 3'd0)
            state_nx = (state == ADDR) ? ACK1 : ACK2;
          else begin
            bitcnt_nx = bitcnt - 3'd1;
            shift_nx  = {shift[6:0], 1'b0};
          end
        end
      end
      ACK1, ACK2: begin
        if (tick && q == 2'd1 && sda_i)
          aerr_nx = 1'b1;
        if (tick && q == 2'd3) begin
          // an address NACK skips the data byte
          if (state == ACK2 || ack_err)
            state_nx = STOP;
          else begin
            state_nx  = DATA;
            shift_nx  = dbyte;
            bitcnt_nx = 3'd7;
          end
        end
      end
      STOP: begin
        if (tick && q == 2'd3) begin
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // bus levels follow the next state so the pins stay registered
  always_comb begin
    scl_nx = 1'b1;
    oe_nx  = 1'b0;
    unique case (state_nx)
      IDLE: begin
        scl_nx = 1'b1;
        oe_nx  = 1'b0;
      end
      START: begin
        scl_nx = (q_nx != 2'd3);
        oe_nx  = q_nx[1];
      end
      ADDR, DATA: begin
        scl_nx = ^q_nx;
        oe_nx  = ~shift_nx[7];
      end
      ACK1, ACK2: begin
        scl_nx = ^q_nx;
        oe_nx  = 1'b0;
      end
      STOP: begin
        scl_nx = (q_nx != 2'd0);
        oe_nx  = ~q_nx[1];
      end
      default: begin
        scl_nx = 1'b1;
        oe_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      q       <= 2'd0;
      div     <= '0;
      bitcnt  <= 3'd0;
      shift   <= 8'd0;
      dbyte   <= 8'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
    end else begin
      state   <= state_nx;
      q       <= q_nx;
      div     <= div_nx;
      bitcnt  <= bitcnt_nx;
      shift   <= shift_nx;
      dbyte   <= dbyte_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      ack_err <= aerr_nx;
      scl     <= scl_nx;
      sda_oe  <= oe_nx;
    end
  end

endmodule

// File: tb/tb_i2c_master_tx.sv
// tb_i2c_master_tx: bus-level model check of i2c_master_tx.
// Decodes SDA at SCL rises and acts as an ACKing slave.
module tb_i2c_master_tx;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       n_rst, start;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic       busy, done, ack_err, scl, sda_oe, sda_i;

  int errors = 0;
  int checks = 0;

  bit rx[$];
  int cnt, starts, stops;
  bit nack1, nack2;

  i2c_master_tx #(.CLK_DIV(D)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .addr(addr),
    .wdata(wdata), .busy(busy), .done(done), .ack_err(ack_err),
    .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  // slave + bus monitor; the slave pulls SDA while SCL is high in an ACK slot
  initial begin : mon
    logic pscl, psda;
    pscl = 1'b1; psda = 1'b0;
    cnt = 0; starts = 0; stops = 0;
    sda_i = 1'b1;
    forever begin
      @(negedge clk);
      if (scl === 1'b1 && pscl === 1'b0) begin
        rx.push_back(~sda_oe);
        cnt++;
      end
      if (scl === 1'b1 && pscl === 1'b1 && sda_oe === 1'b1 && psda === 1'b0) begin
        starts++;
        cnt = 0;
      end
      if (scl === 1'b1 && pscl === 1'b1 && sda_oe === 1'b0 && psda === 1'b1)
        stops++;
      sda_i = ~(sda_oe | (scl &&
              ((cnt == 9 && !nack1) || (cnt == 18 && !nack2))));
      pscl = scl;
      psda = sda_oe;
    end
  end

  task automatic mon_clear();
    rx.delete();
    cnt = 0; starts = 0; stops = 0;
  endtask

  function automatic logic [31:0] rx_vec();
    logic [31:0] v;
    v = '0;
    foreach (rx[i]) v = {v[30:0], logic'(rx[i])};
    return v;
  endfunction

  // bits seen at SCL rises: addr+W, released ACK, [data, released ACK], STOP low
  function automatic int exp_len(bit n1);
    return n1 ? 10 : 19;
  endfunction

  function automatic logic [31:0] exp_vec(logic [6:0] a, logic [7:0] d, bit n1);
    if (n1) return {22'd0, a, 1'b0, 1'b1, 1'b0};
    return {13'd0, a, 1'b0, 1'b1, d, 1'b1, 1'b0};
  endfunction

  function automatic int exp_lat(bit n1);
    return (4 + 8 * 4 + 4 + (n1 ? 0 : 8 * 4 + 4) + 4) * D;
  endfunction

  task automatic do_xfer(input logic [6:0] a, input logic [7:0] d,
                         input bit spam, output int lat,
                         output logic busy_acc, output logic aerr_acc);
    if (start !== 1'b1) begin
      @(negedge clk);
      addr = a; wdata = d; start = 1'b1;
    end else begin
      addr = a; wdata = d;
    end
    @(posedge clk); #1;
    start = 1'b0;
    busy_acc = busy;
    aerr_acc = ack_err;
    lat = -1;
    for (int i = 1; i <= 1000; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (spam) start = ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl got=%b want=1", scl); end
    checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b want=0", sda_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (ack_err !== 1'b0) begin errors++; $display("FAIL reset_aerr got=%b want=0", ack_err); end
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || scl !== 1'b1) begin errors++; $display("FAIL idle_after_reset busy=%b scl=%b want 0/1", busy, scl); end
  endtask

  task automatic test_full();
    int lat; logic ba, aa;
    nack1 = 0; nack2 = 0;
    mon_clear();
    do_xfer(7'h3C, 8'hA5, 1'b0, lat, ba, aa);
    checks++; if (lat !== exp_lat(0)) begin errors++; $display("FAIL full_lat got=%0d want=%0d", lat, exp_lat(0)); end
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL full_busy_acc got=%b want=1", ba); end
    checks++; if (rx.size() !== exp_len(0)) begin errors++; $display("FAIL full_len got=%0d want=%0d", rx.size(), exp_len(0)); end
    checks++; if (rx_vec() !== exp_vec(7'h3C, 8'hA5, 0)) begin errors++; $display("FAIL full_bits got=%h want=%h", rx_vec(), exp_vec(7'h3C, 8'hA5, 0)); end
    checks++; if (ack_err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_status aerr=%b busy=%b want 0/0", ack_err, busy); end
    checks++; if (starts !== 1 || stops !== 1) begin errors++; $display("FAIL full_cond starts=%0d stops=%0d want 1/1", starts, stops); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse got=%b want=0", done); end
    checks++; if (scl !== 1'b1 || sda_oe !== 1'b0) begin errors++; $display("FAIL full_idle scl=%b oe=%b want 1/0", scl, sda_oe); end
  endtask

  task automatic test_nack_addr();
    int lat; logic ba, aa;
    nack1 = 1; nack2 = 0;
    mon_clear();
    do_xfer(7'h3C, 8'hA5, 1'b0, lat, ba, aa);
    checks++; if (lat !== exp_lat(1)) begin errors++; $display("FAIL nack1_lat got=%0d want=%0d", lat, exp_lat(1)); end
    checks++; if (rx.size() !== exp_len(1)) begin errors++; $display("FAIL nack1_len got=%0d want=%0d", rx.size(), exp_len(1)); end
    checks++; if (rx_vec() !== exp_vec(7'h3C, 8'hA5, 1)) begin errors++; $display("FAIL nack1_bits got=%h want=%h", rx_vec(), exp_vec(7'h3C, 8'hA5, 1)); end
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack1_aerr got=%b want=1", ack_err); end
    checks++; if (stops !== 1) begin errors++; $display("FAIL nack1_stop got=%0d want=1", stops); end
    nack1 = 0;
  endtask

  task automatic test_nack_data();
    int lat; logic ba, aa;
    logic [6:0] a; logic [7:0] d;
    nack1 = 0; nack2 = 1;
    mon_clear();
    do_xfer(7'h3C, 8'hA5, 1'b0, lat, ba, aa);
    checks++; if (lat !== exp_lat(0)) begin errors++; $display("FAIL nack2_lat got=%0d want=%0d", lat, exp_lat(0)); end
    checks++; if (rx_vec() !== exp_vec(7'h3C, 8'hA5, 0)) begin errors++; $display("FAIL nack2_bits got=%h want=%h", rx_vec(), exp_vec(7'h3C, 8'hA5, 0)); end
    checks++; if (ack_err !== 1'b1) begin errors++; $display("FAIL nack2_aerr got=%b want=1", ack_err); end
    nack2 = 0;
    a = 7'($urandom); d = 8'($urandom);
    mon_clear();
    do_xfer(a, d, 1'b0, lat, ba, aa);
    checks++; if (aa !== 1'b0) begin errors++; $display("FAIL aerr_clear_on_accept got=%b want=0", aa); end
    checks++; if (rx_vec() !== exp_vec(a, d, 0)) begin errors++; $display("FAIL after_nack_bits got=%h want=%h", rx_vec(), exp_vec(a, d, 0)); end
  endtask

  task automatic test_busy_ignore();
    int lat, extra; logic ba, aa;
    nack1 = 0; nack2 = 0;
    mon_clear();
    do_xfer(7'h3C, 8'hA5, 1'b1, lat, ba, aa);
    checks++; if (lat !== exp_lat(0)) begin errors++; $display("FAIL spam_lat got=%0d want=%0d", lat, exp_lat(0)); end
    checks++; if (rx_vec() !== exp_vec(7'h3C, 8'hA5, 0) || rx.size() !== exp_len(0)) begin errors++; $display("FAIL spam_bits got=%h want=%h", rx_vec(), exp_vec(7'h3C, 8'hA5, 0)); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL spam_extra got=%0d want=0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat, n; logic ba, aa;
    logic [6:0] a; logic [7:0] d;
    nack1 = 0; nack2 = 0;
    mon_clear();
    @(negedge clk);
    addr = 7'h55; wdata = 8'hC3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (rx.size() < 14 && n < 1000) begin
      @(posedge clk); #2;
      n++;
    end
    checks++; if (rx.size() < 14) begin errors++; $display("FAIL rst_mid_reach got=%0d want=14", rx.size()); end
    n_rst = 1'b0;
    #1;
    checks++; if (scl !== 1'b1 || sda_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_bus scl=%b oe=%b want 1/0", scl, sda_oe); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_flags busy=%b done=%b want 0/0", busy, done); end
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    mon_clear();
    a = 7'($urandom); d = 8'($urandom);
    do_xfer(a, d, 1'b0, lat, ba, aa);
    checks++; if (lat !== exp_lat(0)) begin errors++; $display("FAIL rst_after_lat got=%0d want=%0d", lat, exp_lat(0)); end
    checks++; if (rx_vec() !== exp_vec(a, d, 0)) begin errors++; $display("FAIL rst_after_bits got=%h want=%h", rx_vec(), exp_vec(a, d, 0)); end
  endtask

  task automatic test_back_to_back();
    int lat; logic ba, aa;
    logic [6:0] a; logic [7:0] d;
    nack1 = 0; nack2 = 0;
    a = 7'($urandom); d = 8'($urandom);
    mon_clear();
    do_xfer(a, d, 1'b0, lat, ba, aa);
    checks++; if (lat !== exp_lat(0)) begin errors++; $display("FAIL b2b_first_lat got=%0d want=%0d", lat, exp_lat(0)); end
    addr = 7'h01; wdata = 8'h00; start = 1'b1;
    mon_clear();
    do_xfer(7'h01, 8'h00, 1'b0, lat, ba, aa);
    checks++; if (ba !== 1'b1) begin errors++; $display("FAIL b2b_no_gap busy=%b want=1", ba); end
    checks++; if (lat !== exp_lat(0)) begin errors++; $display("FAIL b2b_lat got=%0d want=%0d", lat, exp_lat(0)); end
    checks++; if (rx_vec() !== exp_vec(7'h01, 8'h00, 0)) begin errors++; $display("FAIL b2b_bits got=%h want=%h", rx_vec(), exp_vec(7'h01, 8'h00, 0)); end
  endtask

  task automatic test_random();
    int lat; logic ba, aa;
    logic [6:0] a; logic [7:0] d;
    for (int k = 0; k < 4; k++) begin
      a = 7'($urandom); d = 8'($urandom);
      nack1 = bit'($urandom_range(0, 1));
      nack2 = bit'($urandom_range(0, 1));
      mon_clear();
      do_xfer(a, d, 1'b0, lat, ba, aa);
      checks++; if (lat !== exp_lat(nack1)) begin errors++; $display("FAIL rnd%0d_lat got=%0d want=%0d", k, lat, exp_lat(nack1)); end
      checks++; if (rx_vec() !== exp_vec(a, d, nack1) || rx.size() !== exp_len(nack1)) begin errors++; $display("FAIL rnd%0d_bits got=%h want=%h", k, rx_vec(), exp_vec(a, d, nack1)); end
      checks++; if (ack_err !== (nack1 | (nack2 & ~nack1))) begin errors++; $display("FAIL rnd%0d_aerr got=%b want=%b", k, ack_err, nack1 | (nack2 & ~nack1)); end
    end
    nack1 = 0; nack2 = 0;
  endtask

  initial begin
    nack1 = 0; nack2 = 0;
    test_reset();
    test_full();
    test_nack_addr();
    test_nack_data();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
